// File: rtl/vga_timing_core.sv
// vga_timing_core: parametrised VGA raster timing generator with a latency-
// compensated request/response pixel stage and 8-bit DAC channel expansion.
module vga_timing_core #(
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 16,
    parameter int H_PULSE  = 96,
    parameter int H_BACK   = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10,
    parameter int V_PULSE  = 2,
    parameter int V_BACK   = 33,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int R_BITS   = 3,
    parameter int G_BITS   = 3,
    parameter int B_BITS   = 2,
    parameter int LAT      = 1
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              clk_en,
    input  logic [R_BITS+G_BITS+B_BITS-1:0]   color_in,
    output logic                              req_valid,
    output logic [11:0]                       req_x,
    output logic [11:0]                       req_y,
    output logic                              line_start,
    output logic                              frame_start,
    output logic [15:0]                       frame_count,
    output logic                              hsync,
    output logic                              vsync,
    output logic                              de,
    output logic [7:0]                        red,
    output logic [7:0]                        green,
    output logic [7:0]                        blue,
    output logic                              blank_n,
    output logic                              sync_n,
    output logic                              clk
);

    localparam int CW      = R_BITS + G_BITS + B_BITS;
    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_PULSE + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_PULSE + V_BACK;

    localparam logic [11:0] H_ACT  = 12'(H_ACTIVE);
    localparam logic [11:0] HS_BEG = 12'(H_ACTIVE + H_FRONT);
    localparam logic [11:0] HS_END = 12'(H_ACTIVE + H_FRONT + H_PULSE);
    localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_ACT  = 12'(V_ACTIVE);
    localparam logic [11:0] VS_BEG = 12'(V_ACTIVE + V_FRONT);
    localparam logic [11:0] VS_END = 12'(V_ACTIVE + V_FRONT + V_PULSE);
    localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);
    localparam logic        HS_ON  = 1'(HS_POL);
    localparam logic        VS_ON  = 1'(VS_POL);

    // Replicate an n-bit value (held in c[n-1:0]) MSB-first across 8 bits.
    function automatic logic [7:0] expand(input logic [7:0] c, input int n);
        logic [7:0] o;
        o = '0;
        for (int i = 0; i < 8; i++) begin
            o[3'(7 - i)] = c[3'(n - 1 - (i % n))];
        end
        return o;
    endfunction

    logic [11:0]     r_h_cnt;
    logic [11:0]     r_v_cnt;
    logic [15:0]     r_frame_count;
    logic [LAT-1:0]  r_vis_d;
    logic [LAT-1:0]  r_hs_d;
    logic [LAT-1:0]  r_vs_d;
    logic            r_hsync;
    logic            r_vsync;
    logic            r_de;
    logic [7:0]      r_red;
    logic [7:0]      r_green;
    logic [7:0]      r_blue;

    logic            w_h_last;
    logic            w_v_last;
    logic            w_visible;
    logic            w_hs_act;
    logic            w_vs_act;
    logic [LAT:0]    w_vis_shift;
    logic [LAT:0]    w_hs_shift;
    logic [LAT:0]    w_vs_shift;
    logic [R_BITS-1:0] w_r_in;
    logic [G_BITS-1:0] w_g_in;
    logic [B_BITS-1:0] w_b_in;

    assign w_h_last  = (r_h_cnt == H_LAST);
    assign w_v_last  = (r_v_cnt == V_LAST);
    assign w_visible = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
    assign w_hs_act  = (r_h_cnt >= HS_BEG) && (r_h_cnt < HS_END);
    assign w_vs_act  = (r_v_cnt >= VS_BEG) && (r_v_cnt < VS_END);

    // Each delay line shifts in the current decode at bit 0; bit LAT-1 is the
    // decode from LAT enabled cycles ago, lining up with the returned colour.
    assign w_vis_shift = {r_vis_d, w_visible};
    assign w_hs_shift  = {r_hs_d, w_hs_act};
    assign w_vs_shift  = {r_vs_d, w_vs_act};

    assign w_r_in = color_in[CW-1 -: R_BITS];
    assign w_g_in = color_in[G_BITS+B_BITS-1 -: G_BITS];
    assign w_b_in = color_in[B_BITS-1:0];

    // Request side: req_valid marks a visible counter position; the renderer
    // must present that pixel's colour on color_in exactly LAT enabled cycles
    // later. There is no back-pressure: every request is consumed.
    assign req_valid   = w_visible;
    assign req_x       = w_visible ? r_h_cnt : 12'd0;
    assign req_y       = w_visible ? r_v_cnt : 12'd0;
    assign line_start  = clk_en && (r_h_cnt == 12'd0);
    assign frame_start = clk_en && (r_h_cnt == 12'd0) && (r_v_cnt == 12'd0);
    assign frame_count = r_frame_count;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign de          = r_de;
    assign red         = r_red;
    assign green       = r_green;
    assign blue        = r_blue;
    assign blank_n     = r_de;
    assign sync_n      = 1'b0;
    assign clk         = clock;

    // Raster counters and completed-frame counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_h_cnt       <= 12'd0;
            r_v_cnt       <= 12'd0;
            r_frame_count <= 16'd0;
        end else if (clk_en) begin
            if (w_h_last) begin
                r_h_cnt <= 12'd0;
                r_v_cnt <= w_v_last ? 12'd0 : r_v_cnt + 12'd1;
                if (w_v_last) begin
                    r_frame_count <= r_frame_count + 16'd1;
                end
            end else begin
                r_h_cnt <= r_h_cnt + 12'd1;
            end
        end
    end

    // Latency delay lines and the output register that pairs them with color_in.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_vis_d <= '0;
            r_hs_d  <= '0;
            r_vs_d  <= '0;
            r_hsync <= ~HS_ON;
            r_vsync <= ~VS_ON;
            r_de    <= 1'b0;
            r_red   <= 8'd0;
            r_green <= 8'd0;
            r_blue  <= 8'd0;
        end else if (clk_en) begin
            r_vis_d <= w_vis_shift[LAT-1:0];
            r_hs_d  <= w_hs_shift[LAT-1:0];
            r_vs_d  <= w_vs_shift[LAT-1:0];
            r_hsync <= r_hs_d[LAT-1] ? HS_ON : ~HS_ON;
            r_vsync <= r_vs_d[LAT-1] ? VS_ON : ~VS_ON;
            r_de    <= r_vis_d[LAT-1];
            r_red   <= r_vis_d[LAT-1] ? expand(8'(w_r_in), R_BITS) : 8'd0;
            r_green <= r_vis_d[LAT-1] ? expand(8'(w_g_in), G_BITS) : 8'd0;
            r_blue  <= r_vis_d[LAT-1] ? expand(8'(w_b_in), B_BITS) : 8'd0;
        end
    end

endmodule

// File: tb/tb_vga_timing_core.sv
// tb_vga_timing_core: two small-raster instances (active-low/LAT=1 and
// active-high/LAT=4, different colour widths) checked every cycle against an
// arithmetic raster model, plus expansion vectors and reset/strobe sequences.
module tb_vga_timing_core;

  // Instance A geometry: 23 x 10, frame = 230 enabled cycles
  localparam int A_HA = 16, A_HF = 2, A_HP = 3, A_HB = 2;
  localparam int A_VA = 6,  A_VF = 1, A_VP = 2, A_VB = 1;
  localparam int A_LAT = 1;
  // Instance B geometry: 14 x 7, frame = 98 enabled cycles
  localparam int B_HA = 8, B_HF = 2, B_HP = 2, B_HB = 2;
  localparam int B_VA = 4, B_VF = 1, B_VP = 1, B_VB = 1;
  localparam int B_LAT = 4;

  typedef struct {
    int ha, hf, hp, hb, va, vf, vp, vb;
    int hpol, vpol, r_bits, g_bits, b_bits, lat;
  } geo_t;

  typedef struct packed {
    logic        rv;
    logic [11:0] rx;
    logic [11:0] ry;
    logic        ls;
    logic        fs;
    logic [15:0] fc;
    logic        hs;
    logic        vs;
    logic        de;
    logic        bn;
    logic        sn;
    logic        ck;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
  } obs_t;

  typedef struct packed {
    logic        rv;
    logic [11:0] rx;
    logic [11:0] ry;
  } req_t;

  typedef struct {
    logic [7:0]  col_a;
    logic [7:0]  ra, ga, ba;
    logic [12:0] col_b;
    logic [7:0]  rb, gb, bb;
  } vec_t;

  // ---------------- clock / reset / DUTs ----------------
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        clk_en = 1'b0;
  logic [7:0]  ca = '0;
  logic [12:0] cb = '0;

  always #5 clock = ~clock;

  logic        a_req_valid, a_line_start, a_frame_start, a_hsync, a_vsync, a_de, a_blank_n, a_sync_n, a_clk;
  logic [11:0] a_req_x, a_req_y;
  logic [15:0] a_frame_count;
  logic [7:0]  a_red, a_green, a_blue;
  logic        b_req_valid, b_line_start, b_frame_start, b_hsync, b_vsync, b_de, b_blank_n, b_sync_n, b_clk;
  logic [11:0] b_req_x, b_req_y;
  logic [15:0] b_frame_count;
  logic [7:0]  b_red, b_green, b_blue;

  vga_timing_core #(
    .H_ACTIVE(A_HA), .H_FRONT(A_HF), .H_PULSE(A_HP), .H_BACK(A_HB),
    .V_ACTIVE(A_VA), .V_FRONT(A_VF), .V_PULSE(A_VP), .V_BACK(A_VB),
    .HS_POL(0), .VS_POL(0), .R_BITS(3), .G_BITS(3), .B_BITS(2), .LAT(A_LAT)
  ) u_dut_a (
    .clock(clock), .reset(reset), .clk_en(clk_en), .color_in(ca),
    .req_valid(a_req_valid), .req_x(a_req_x), .req_y(a_req_y),
    .line_start(a_line_start), .frame_start(a_frame_start), .frame_count(a_frame_count),
    .hsync(a_hsync), .vsync(a_vsync), .de(a_de),
    .red(a_red), .green(a_green), .blue(a_blue),
    .blank_n(a_blank_n), .sync_n(a_sync_n), .clk(a_clk)
  );

  vga_timing_core #(
    .H_ACTIVE(B_HA), .H_FRONT(B_HF), .H_PULSE(B_HP), .H_BACK(B_HB),
    .V_ACTIVE(B_VA), .V_FRONT(B_VF), .V_PULSE(B_VP), .V_BACK(B_VB),
    .HS_POL(1), .VS_POL(1), .R_BITS(8), .G_BITS(4), .B_BITS(1), .LAT(B_LAT)
  ) u_dut_b (
    .clock(clock), .reset(reset), .clk_en(clk_en), .color_in(cb),
    .req_valid(b_req_valid), .req_x(b_req_x), .req_y(b_req_y),
    .line_start(b_line_start), .frame_start(b_frame_start), .frame_count(b_frame_count),
    .hsync(b_hsync), .vsync(b_vsync), .de(b_de),
    .red(b_red), .green(b_green), .blue(b_blue),
    .blank_n(b_blank_n), .sync_n(b_sync_n), .clk(b_clk)
  );

  // ---------------- reference model ----------------
  int   n_chk = 0;
  int   n_fail = 0;
  int   e = 0;          // enabled edges since the last reset edge
  logic chk_on = 1'b0;
  logic hold = 1'b0;
  logic [7:0]  hold_a = '0;
  logic [12:0] hold_b = '0;
  req_t hist_a[16];
  req_t hist_b[16];
  geo_t geo_a, geo_b;

  function automatic int hash(input int x, input int y, input int w);
    return (x * 37 + y * 101 + 5) % (1 << w);
  endfunction

  // n-bit value repeated eight times end to end; the top byte is the DAC value
  function automatic logic [7:0] expand_ref(input int c, input int n);
    longint acc;
    acc = 0;
    for (int k = 0; k < 8; k++) acc = (acc << n) | longint'(c);
    return 8'(acc >> (8 * n - 8));
  endfunction

  function automatic obs_t model(input geo_t g, input int cnt, input logic en_now, input logic ck);
    obs_t m;
    int ht, vt, h, v, q, qh, qv, col;
    logic hs_on, vs_on, vis, hp, vp;
    ht = g.ha + g.hf + g.hp + g.hb;
    vt = g.va + g.vf + g.vp + g.vb;
    h = cnt % ht;
    v = (cnt / ht) % vt;
    m.rv = (h < g.ha) && (v < g.va);
    m.rx = m.rv ? 12'(h) : 12'd0;
    m.ry = m.rv ? 12'(v) : 12'd0;
    m.ls = en_now && (h == 0);
    m.fs = en_now && (h == 0) && (v == 0);
    m.fc = 16'((cnt / (ht * vt)) % 65536);
    hs_on = 1'b0; vs_on = 1'b0; vis = 1'b0; qh = 0; qv = 0;
    if (cnt >= g.lat + 1) begin
      q  = cnt - g.lat - 1;
      qh = q % ht;
      qv = (q / ht) % vt;
      hs_on = (qh >= g.ha + g.hf) && (qh < g.ha + g.hf + g.hp);
      vs_on = (qv >= g.va + g.vf) && (qv < g.va + g.vf + g.vp);
      vis   = (qh < g.ha) && (qv < g.va);
    end
    hp = (g.hpol != 0);
    vp = (g.vpol != 0);
    m.hs = hs_on ? hp : !hp;
    m.vs = vs_on ? vp : !vp;
    m.de = vis;
    m.bn = vis;
    m.sn = 1'b0;
    m.ck = ck;
    col = hash(qh, qv, g.r_bits + g.g_bits + g.b_bits);
    m.r = vis ? expand_ref((col >> (g.g_bits + g.b_bits)) % (1 << g.r_bits), g.r_bits) : 8'h00;
    m.g = vis ? expand_ref((col >> g.b_bits) % (1 << g.g_bits), g.g_bits) : 8'h00;
    m.b = vis ? expand_ref(col % (1 << g.b_bits), g.b_bits) : 8'h00;
    return m;
  endfunction

  // ---------------- scoreboard helpers ----------------
  task automatic cmp_obs(input string nm, input obs_t act, input obs_t exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s e=%0d: got rv=%0d x=%0d y=%0d ls=%0d fs=%0d fc=%0d hs=%0d vs=%0d de=%0d bn=%0d sn=%0d ck=%0d rgb=%h_%h_%h, expected rv=%0d x=%0d y=%0d ls=%0d fs=%0d fc=%0d hs=%0d vs=%0d de=%0d bn=%0d sn=%0d ck=%0d rgb=%h_%h_%h",
               nm, e, act.rv, act.rx, act.ry, act.ls, act.fs, act.fc, act.hs, act.vs, act.de, act.bn, act.sn, act.ck, act.r, act.g, act.b,
               exp.rv, exp.rx, exp.ry, exp.ls, exp.fs, exp.fc, exp.hs, exp.vs, exp.de, exp.bn, exp.sn, exp.ck, exp.r, exp.g, exp.b);
    end
  endtask

  task automatic chk1(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  // One clock: update the enabled-edge count, apply next inputs, drive colour
  // from the request made LAT enabled cycles ago, then compare both instances.
  task automatic tick(input logic nen, input logic nrst);
    logic ce, cr;
    obs_t oa, ob;
    req_t ha, hb;
    ce = clk_en;
    cr = reset;
    @(posedge clock);
    if (cr) e = 0;
    else if (ce) e++;
    #1;
    clk_en = nen;
    reset  = nrst;
    hist_a[e % 16] = {a_req_valid, a_req_x, a_req_y};
    hist_b[e % 16] = {b_req_valid, b_req_x, b_req_y};
    if (hold) begin
      ca = hold_a;
      cb = hold_b;
    end else begin
      ca = 8'($urandom);
      cb = 13'($urandom);
      if (e >= A_LAT) begin
        ha = hist_a[(e - A_LAT) % 16];
        if (ha.rv) ca = 8'(hash(int'(ha.rx), int'(ha.ry), 8));
      end
      if (e >= B_LAT) begin
        hb = hist_b[(e - B_LAT) % 16];
        if (hb.rv) cb = 13'(hash(int'(hb.rx), int'(hb.ry), 13));
      end
    end
    #1;
    if (chk_on) begin
      oa = {a_req_valid, a_req_x, a_req_y, a_line_start, a_frame_start, a_frame_count,
            a_hsync, a_vsync, a_de, a_blank_n, a_sync_n, a_clk, a_red, a_green, a_blue};
      ob = {b_req_valid, b_req_x, b_req_y, b_line_start, b_frame_start, b_frame_count,
            b_hsync, b_vsync, b_de, b_blank_n, b_sync_n, b_clk, b_red, b_green, b_blue};
      cmp_obs("model_a", oa, model(geo_a, e, clk_en, clock));
      cmp_obs("model_b", ob, model(geo_b, e, clk_en, clock));
    end
  endtask

  // ---------------- test sequence ----------------
  vec_t vecs[4];

  initial begin
    int cnt_hs, cnt_vs, cnt_de, n;
    logic got_a, got_b;

    geo_a = '{A_HA, A_HF, A_HP, A_HB, A_VA, A_VF, A_VP, A_VB, 0, 0, 3, 3, 2, A_LAT};
    geo_b = '{B_HA, B_HF, B_HP, B_HB, B_VA, B_VF, B_VP, B_VB, 1, 1, 8, 4, 1, B_LAT};

    vecs[0] = '{8'b101_010_10, 8'hB6, 8'h49, 8'hAA, {8'h3C, 4'b1010, 1'b1}, 8'h3C, 8'hAA, 8'hFF};
    vecs[1] = '{8'hFF,         8'hFF, 8'hFF, 8'hFF, {8'hA5, 4'b0110, 1'b0}, 8'hA5, 8'h66, 8'h00};
    vecs[2] = '{8'b100_011_01, 8'h92, 8'h6D, 8'h55, {8'h00, 4'b1111, 1'b1}, 8'h00, 8'hFF, 8'hFF};
    vecs[3] = '{8'b011_111_00, 8'h6D, 8'hFF, 8'h00, {8'hFF, 4'b0001, 1'b0}, 8'hFF, 8'h11, 8'h00};

    // reset, then the reset-state cycle with clk_en high
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    chk_on = 1'b1;
    tick(1'b1, 1'b0);
    chk1("rst_de_a", int'(a_de), 0);
    chk1("rst_hsync_a", int'(a_hsync), 1);
    chk1("rst_vsync_b", int'(b_vsync), 0);
    chk1("rst_red_a", int'(a_red), 0);
    chk1("rst_fc_a", int'(a_frame_count), 0);
    chk1("rst_frame_start_a", int'(a_frame_start), 1);
    chk1("rst_req_valid_b", int'(b_req_valid), 1);

    // continuous enable: three frames of A
    for (int i = 0; i < 700; i++) tick(1'b1, 1'b0);

    // whole-frame windows: pulse widths and de counts
    cnt_hs = 0; cnt_vs = 0; cnt_de = 0;
    for (int i = 0; i < 230; i++) begin
      tick(1'b1, 1'b0);
      if (!a_hsync) cnt_hs++;
      if (!a_vsync) cnt_vs++;
      if (a_de) cnt_de++;
    end
    chk1("frame_hsync_low_a", cnt_hs, A_HP * 10);
    chk1("frame_vsync_low_a", cnt_vs, A_VP * 23);
    chk1("frame_de_a", cnt_de, A_HA * A_VA);
    cnt_hs = 0; cnt_vs = 0; cnt_de = 0;
    for (int i = 0; i < 98; i++) begin
      tick(1'b1, 1'b0);
      if (b_hsync) cnt_hs++;
      if (b_vsync) cnt_vs++;
      if (b_de) cnt_de++;
    end
    chk1("frame_hsync_high_b", cnt_hs, B_HP * 7);
    chk1("frame_vsync_high_b", cnt_vs, B_VP * 14);
    chk1("frame_de_b", cnt_de, B_HA * B_VA);

    // random clk_en with occasional random resets
    for (int i = 0; i < 3000; i++)
      tick(1'($urandom_range(0, 1)), ($urandom_range(0, 299) == 0));

    // strict 1-in-2 enable
    for (int i = 0; i < 1000; i++) tick(1'(i % 2), 1'b0);

    // reset mid-frame at A position (10,4), applied with clk_en low
    n = 0;
    while ((e % 230) != (4 * 23 + 10) && n < 1000) begin
      tick(1'b1, 1'b0);
      n++;
    end
    chk1("midreset_reach_timeout", n < 1000 ? 1 : 0, 1);
    chk1("midreset_de_before_a", int'(a_de), 1);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    chk1("midreset_de_a", int'(a_de), 0);
    chk1("midreset_hsync_a", int'(a_hsync), 1);
    chk1("midreset_req_x_a", int'(a_req_x), 0);
    chk1("midreset_fc_a", int'(a_frame_count), 0);
    chk1("midreset_frame_start_en0_a", int'(a_frame_start), 0);
    tick(1'b1, 1'b0);
    chk1("release_frame_start_a", int'(a_frame_start), 1);
    chk1("release_req_valid_a", int'(a_req_valid), 1);
    chk1("release_req_y_a", int'(a_req_y), 0);

    // expansion vectors with colour held constant
    chk_on = 1'b0;
    hold = 1'b1;
    for (int v = 0; v < 4; v++) begin
      hold_a = vecs[v].col_a;
      hold_b = vecs[v].col_b;
      got_a = 1'b0; got_b = 1'b0; n = 0;
      while (!(got_a && got_b) && n < 400) begin
        tick(1'b1, 1'b0);
        n++;
        if (n >= 6 && a_de && !got_a) begin
          got_a = 1'b1;
          chk1($sformatf("expand_red_a[%0d]", v), int'(a_red), int'(vecs[v].ra));
          chk1($sformatf("expand_green_a[%0d]", v), int'(a_green), int'(vecs[v].ga));
          chk1($sformatf("expand_blue_a[%0d]", v), int'(a_blue), int'(vecs[v].ba));
        end
        if (n >= 6 && b_de && !got_b) begin
          got_b = 1'b1;
          chk1($sformatf("expand_red_b[%0d]", v), int'(b_red), int'(vecs[v].rb));
          chk1($sformatf("expand_green_b[%0d]", v), int'(b_green), int'(vecs[v].gb));
          chk1($sformatf("expand_blue_b[%0d]", v), int'(b_blue), int'(vecs[v].bb));
        end
      end
      chk1($sformatf("expand_de_timeout[%0d]", v), (got_a && got_b) ? 1 : 0, 1);
    end
    hold = 1'b0;
    tick(1'b1, 1'b1);
    chk_on = 1'b1;
    tick(1'b1, 1'b0);

    // long run: many frames, frame counters
    for (int i = 0; i < 20000; i++) tick(1'b1, 1'b0);
    chk1("frame_count_a", int'(a_frame_count), (e / 230) % 65536);
    chk1("frame_count_b", int'(b_frame_count), (e / 98) % 65536);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
